// File: rtl/y86_pipe_stage_reg_if.sv
// y86_pipe_stage_reg_if: control, payload and status bundle for one pipeline
// stage register. The pipeline control logic uses the master modport and the
// stage register uses the slave modport.
interface y86_pipe_stage_reg_if #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 32
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              stall_i;
  logic              bubble_i;
  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic              conflict_clr_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic [OCC_W-1:0]  occupancy_o;
  logic              conflict_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport master (
    output stall_i, bubble_i, valid_i, data_i, conflict_clr_i,
    input  data_o, valid_o, occupancy_o, conflict_o, stall_cnt_o, bubble_cnt_o
  );

  modport slave (
    input  stall_i, bubble_i, valid_i, data_i, conflict_clr_i,
    output data_o, valid_o, occupancy_o, conflict_o, stall_cnt_o, bubble_cnt_o
  );
endinterface

// File: rtl/y86_pipe_stage_reg.sv
// y86_pipe_stage_reg: generic Y86-64 pipeline stage register with DEPTH slots,
// stall (hold all), bubble (flush entry slot to BUBBLE_VAL), per-slot valid
// tracking, a sticky stall/bubble conflict flag and optional saturating hazard
// counters enabled by defining Y86_PIPE_REG_PERF_EN.
module y86_pipe_stage_reg #(
  parameter int                DATA_W     = 64,
  parameter int                DEPTH      = 1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                CNT_W      = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  y86_pipe_stage_reg_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] slot_data [DEPTH];
  logic [DEPTH-1:0]  slot_valid;
  logic [OCC_W-1:0]  occ;
  logic              conflict_q;

  // Slot chain: stall holds everything, otherwise shift; the entry slot takes
  // either the bubble pattern (invalid) or the upstream payload.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        slot_data[k] <= BUBBLE_VAL;
      end
      slot_valid <= '0;
    end else if (!bus.stall_i) begin
      slot_data[0]  <= bus.bubble_i ? BUBBLE_VAL : bus.data_i;
      slot_valid[0] <= bus.valid_i & ~bus.bubble_i;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        slot_data[k]  <= slot_data[k-1];
        slot_valid[k] <= slot_valid[k-1];
      end
    end
  end

  // Occupancy is the population count of the slot valid bits.
  always_comb begin
    occ = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      occ = occ + OCC_W'(slot_valid[k]);
    end
  end

  // Sticky conflict flag; a new conflict outranks a coincident clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conflict_q <= 1'b0;
    end else if (bus.stall_i && bus.bubble_i) begin
      conflict_q <= 1'b1;
    end else if (bus.conflict_clr_i) begin
      conflict_q <= 1'b0;
    end
  end

  assign bus.data_o      = slot_data[DEPTH-1];
  assign bus.valid_o     = slot_valid[DEPTH-1];
  assign bus.occupancy_o = occ;
  assign bus.conflict_o  = conflict_q;

`ifdef Y86_PIPE_REG_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  // Saturating hazard counters; the clear takes precedence over counting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (bus.conflict_clr_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (bus.stall_i && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (bus.bubble_i && !bus.stall_i && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cnt_o  = stall_cnt_q;
  assign bus.bubble_cnt_o = bubble_cnt_q;
`else
  assign bus.stall_cnt_o  = CNT_W'(0);
  assign bus.bubble_cnt_o = CNT_W'(0);
`endif

endmodule

// File: tb/tb_y86_pipe_stage_reg.sv
// tb_y86_pipe_stage_reg: directed per-cycle vectors with hand-computed expected
// outputs; the driver queues each expectation and a separate monitor checks it
// after the corresponding clock edge.
module tb_y86_pipe_stage_reg;
  localparam int          DW  = 16;
  localparam int          DEP = 3;
  localparam int          CW  = 4;
  localparam logic [15:0] BV  = 16'h00F0;

  typedef struct {
    logic        rst, stall, bubble, valid, clr;
    logic [15:0] din;
    logic [15:0] edata;
    logic        evalid;
    logic [1:0]  eocc;
    logic        econf;
    logic [3:0]  esc, ebc;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] data;
    logic        valid;
    logic [1:0]  occ;
    logic        conf;
    logic [3:0]  sc, bc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  y86_pipe_stage_reg_if #(.DATA_W(DW), .DEPTH(DEP), .CNT_W(CW)) bus ();

  y86_pipe_stage_reg #(
    .DATA_W(DW), .DEPTH(DEP), .BUBBLE_VAL(BV), .CNT_W(CW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[$];
  int   async_idx = -1;

  function automatic vec_t mk(logic r, logic s, logic b, logic v, logic c,
                              logic [15:0] d, logic [15:0] ed, logic ev,
                              logic [1:0] eo, logic ec, logic [3:0] es,
                              logic [3:0] eb);
    vec_t t;
    t.rst = r; t.stall = s; t.bubble = b; t.valid = v; t.clr = c; t.din = d;
    t.edata = ed; t.evalid = ev; t.eocc = eo; t.econf = ec;
    t.esc = es; t.ebc = eb;
    return t;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
    end
  endtask

  // Monitor: compare outputs shortly after each rising edge against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("data_o",       e.idx, 32'(bus.data_o),       32'(e.data));
        chk("valid_o",      e.idx, 32'(bus.valid_o),      32'(e.valid));
        chk("occupancy_o",  e.idx, 32'(bus.occupancy_o),  32'(e.occ));
        chk("conflict_o",   e.idx, 32'(bus.conflict_o),   32'(e.conf));
        chk("stall_cnt_o",  e.idx, 32'(bus.stall_cnt_o),  32'(e.sc));
        chk("bubble_cnt_o", e.idx, 32'(bus.bubble_cnt_o), 32'(e.bc));
      end
    end
  end

  // Driver: apply one vector per cycle on the falling edge.
  initial begin
    exp_t e;
    bus.stall_i = 1'b0; bus.bubble_i = 1'b0; bus.valid_i = 1'b0;
    bus.data_i = '0; bus.conflict_clr_i = 1'b0;

    //             rst st bu va cl din       edata     ev occ cf sc bc
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h00, BV,       0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'h11, BV,       0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'h22, BV,       0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'h33, 16'h11,   1, 3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 16'h44, 16'h11,   1, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'h44, 16'h22,   1, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 16'h55, 16'h33,   1, 2, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h66, 16'h44,   1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'h77, BV,       0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 16'h88, BV,       0, 1, 1, 2, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'h99, 16'h66,   0, 2, 1, 2, 1));
    vecs.push_back(mk(0, 1, 0, 1, 1, 16'hA1, 16'h66,   0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 16'hA2, 16'h66,   0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 16'hA3, 16'h77,   1, 2, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 16'hA4, 16'h99,   1, 1, 1, 0, 2));
    vecs.push_back(mk(0, 0, 1, 1, 0, 16'hA5, BV,       0, 0, 1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 1, 1, 16'hAB, BV,       0, 1, 0, 0, 0));
    for (int k = 1; k <= 20; k++) begin
      vecs.push_back(mk(0, 1, 0, 1, 0, 16'(16'hC0 + k), BV, 0, 1, 0,
                        4'((k > 15) ? 15 : k), 0));
    end
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'h12, BV,       0, 2, 0, 15, 0));
    async_idx = vecs.size();
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'h34, 16'hAB,   1, 3, 0, 15, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 16'h55, BV,       0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'h56, BV,       0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'h78, BV,       0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'h9A, 16'h56,   1, 3, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst                = vecs[i].rst;
      bus.stall_i        = vecs[i].stall;
      bus.bubble_i       = vecs[i].bubble;
      bus.valid_i        = vecs[i].valid;
      bus.conflict_clr_i = vecs[i].clr;
      bus.data_i         = vecs[i].din;
      e.idx   = i;
      e.data  = vecs[i].edata;
      e.valid = vecs[i].evalid;
      e.occ   = vecs[i].eocc;
      e.conf  = vecs[i].econf;
`ifdef Y86_PIPE_REG_PERF_EN
      e.sc    = vecs[i].esc;
      e.bc    = vecs[i].ebc;
`else
      e.sc    = 4'd0;
      e.bc    = 4'd0;
`endif
      sb.push_back(e);
      if (i == async_idx) begin
        // Reset asserted between edges must clear the outputs immediately.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_data_o",      i, 32'(bus.data_o),      32'(BV));
        chk("async_valid_o",     i, 32'(bus.valid_o),     32'd0);
        chk("async_occupancy_o", i, 32'(bus.occupancy_o), 32'd0);
        chk("async_stall_cnt_o", i, 32'(bus.stall_cnt_o), 32'd0);
      end
    end

    repeat (3) @(posedge clk);
    #4;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/y86_pipe_stage_reg.md
# y86_pipe_stage_reg

Parametrised pipeline-stage register for the Y86-64 pipeline: a generic replacement for the hand-written per-stage F/D/E/M/W registers. It carries an arbitrary-width payload through `DEPTH` register slots with stall (hold), bubble (flush to a programmable NOP pattern) and per-slot valid tracking. It also flags stall/bubble conflicts and, optionally, counts hazard cycles. It sits between any two pipeline stages and is driven by the pipeline control logic.

## Interface
Parameters:
- `DATA_W`, 64: payload width in bits (≥1).
- `DEPTH`, 1: number of register slots in series (1–8); latency in unstalled cycles.
- `BUBBLE_VAL`, all-zero: `DATA_W`-bit payload loaded on bubble and on reset. Stage wrappers set the icode field to `INOP`.
- `CNT_W`, 32: width of the performance counters (≥4).

Ports:
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: **asynchronous, active-high reset**.
- `stall_i` input 1: hold all slots.
- `bubble_i` input 1: flush the entry slot to `BUBBLE_VAL`.
- `valid_i` input 1: input payload is a real instruction.
- `data_i` input `DATA_W`: payload from the upstream stage.
- `data_o` output `DATA_W`: payload of the last slot.
- `valid_o` output 1: valid bit of the last slot.
- `occupancy_o` output `$clog2(DEPTH+1)`: count of valid slots.
- `conflict_o` output 1: sticky; set when `stall_i` and `bubble_i` are both high on a clock edge.
- `conflict_clr_i` input 1: synchronous clear of `conflict_o`.
- `stall_cnt_o` output `CNT_W`: stalled cycles (perf build only).
- `bubble_cnt_o` output `CNT_W`: bubble cycles (perf build only).

## Operation
- Slots S[0]..S[DEPTH-1]. Each slot holds payload plus a valid bit. S[0] is the entry slot and S[DEPTH-1] drives the outputs.
- Priority per edge: stall > bubble > advance.
  - **Stall:** every slot holds, including valid bits. Outputs are unchanged.
  - **Bubble** (no stall): S[0] ← `BUBBLE_VAL` with valid=0. S[k] ← S[k-1] for k≥1. Only the entry slot is flushed; instructions already downstream continue.
  - **Advance:** S[0] ← `data_i` with valid=`valid_i`. S[k] ← S[k-1].
- With DEPTH=1, behaviour equals a classic stage register: stall holds, bubble outputs the NOP pattern, otherwise it captures the input.
- `occupancy_o` is computed combinationally from the slot valid bits.
- Conflict:
  - `conflict_o` sets on any edge with `stall_i`=`bubble_i`=1. The stall still wins.
  - `conflict_clr_i` clears it. If set and clear coincide, set wins.
  - Not cleared by stall.
- Payload is opaque. No field decoding or arithmetic is performed on `data_i`.

## Timing
- Reset (async assert; deassert sampled on the clock): all slots = `BUBBLE_VAL`, all valid bits = 0, `data_o`=`BUBBLE_VAL`, `valid_o`=0, `occupancy_o`=0, `conflict_o`=0, counters=0.
- Latency: `DEPTH` unstalled edges from `data_i` to `data_o`. Each stall cycle adds one.
- Outputs change only on a clock edge or on reset assertion. There is no combinational path from inputs to `data_o`/`valid_o`.
- Reset mid-stall or mid-bubble: the reset takes effect immediately. The first post-reset edge obeys the inputs normally.
- Back-to-back bubbles insert one invalid slot per cycle. After `DEPTH` consecutive bubbles the chain is entirely `BUBBLE_VAL`/invalid.

## Configuration
- Macro: `Y86_PIPE_REG_PERF_EN`.
- **Defined:**
  - `stall_cnt_o` increments on every edge with `stall_i`=1.
  - `bubble_cnt_o` increments on every edge with `bubble_i`=1 and `stall_i`=0.
  - Both saturate at 2^`CNT_W`−1 and never wrap.
  - Both reset to 0 and are cleared together by `conflict_clr_i`.
- **Undefined:** no counter flops are built, and both outputs are tied to 0.

## Test plan
- **Reset/latency:** `DEPTH`=3, `data_i`=0x11,0x22,0x33 with `valid_i`=1 on successive cycles → `data_o`=0x11 with `valid_o`=1 exactly 3 edges after the first input; `occupancy_o`=3.
- **Stall:** `DEPTH`=1, load 0xABCD then hold `stall_i`=1 for 4 cycles while `data_i` changes → `data_o` stays 0xABCD; with perf enabled, `stall_cnt_o`=4.
- **Bubble:** `DEPTH`=2 full of valid 0x5/0x6, pulse `bubble_i` for 1 cycle → `data_o`=0x6 next, then `BUBBLE_VAL` with `valid_o`=0 on the following edge; `occupancy_o` drops to 1.
- **Conflict:** `stall_i`=`bubble_i`=1 on one edge → slots hold and `conflict_o`=1. Assert `conflict_clr_i` → `conflict_o`=0 on the next edge. Assert set and clear on the same edge → `conflict_o` stays 1.
- **Async reset:** assert `rst_i` mid-cycle with a full `DEPTH`=4 chain → `valid_o`=0, `data_o`=`BUBBLE_VAL` and `occupancy_o`=0 before the next edge.
- **Saturation:** perf enabled, `CNT_W`=4, 20 stall cycles → `stall_cnt_o`=15 and holds there.
